// File: rtl/async_queue_pkg.sv
// Shared helpers for the async queue: Gray-code conversion and legal parameter ranges.
package async_queue_pkg;

    localparam int LOG_DEPTH_MIN = 1;
    localparam int LOG_DEPTH_MAX = 6;
    localparam int SYNC_MIN      = 2;
    localparam int SYNC_MAX      = 4;
    localparam int GRAY_W        = LOG_DEPTH_MAX + 1;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_sync_chain.sv
// Multi-flop synchronizer for signals crossing into the sink clock domain; clears to 0 on reset.
module async_sync_chain #(
    parameter int W      = 1,
    parameter int STAGES = 3
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [STAGES];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/async_rx_queue.sv
// Sink side of a Gray-pointer async FIFO with a one-entry output register.
// Optional source-reset / pointer-valid handshake enabled by ASYNC_RX_QUEUE_SAFE_EN.
module async_rx_queue
    import async_queue_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 3,
    parameter int SYNC      = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_deq_ready,
    output logic                          io_deq_valid,
    output logic [WIDTH-1:0]              io_deq_bits,
    input  logic [(1<<LOG_DEPTH)*WIDTH-1:0] io_async_mem,
    input  logic [LOG_DEPTH:0]            io_async_widx,
    output logic [LOG_DEPTH:0]            io_async_ridx
`ifdef ASYNC_RX_QUEUE_SAFE_EN
    ,
    input  logic                          io_async_safe_widx_valid,
    input  logic                          io_async_safe_source_reset_n,
    output logic                          io_async_safe_ridx_valid,
    output logic                          io_async_safe_sink_reset_n
`endif
);

    localparam int PW = LOG_DEPTH + 1;

    generate
        if (LOG_DEPTH < LOG_DEPTH_MIN || LOG_DEPTH > LOG_DEPTH_MAX) begin : g_bad_depth
            $error("async_rx_queue: LOG_DEPTH out of range");
        end
        if (SYNC < SYNC_MIN || SYNC > SYNC_MAX) begin : g_bad_sync
            $error("async_rx_queue: SYNC out of range");
        end
    endgenerate

    logic [PW-1:0]        r_rd;
    logic [PW-1:0]        r_ridx;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_bits;

    logic [PW-1:0]        w_widx_s;
    logic [GRAY_W-1:0]    w_rd_gray;
    logic [LOG_DEPTH-1:0] w_idx;
    logic [WIDTH-1:0]     w_entry;
    logic                 w_rst;
    logic                 w_gate;
    logic                 w_nonempty;
    logic                 w_load;

`ifdef ASYNC_RX_QUEUE_SAFE_EN
    logic w_src_rst_n_s;
    logic w_widx_valid_s;
    logic r_ridx_valid;
    logic r_sink_rst_n;

    // The source-reset synchronizer only answers to the local reset, otherwise it could never release.
    async_sync_chain #(.W(1), .STAGES(SYNC)) u_sync_src_rst (
        .i_clock (clock),
        .i_reset (reset),
        .i_d     (io_async_safe_source_reset_n),
        .o_q     (w_src_rst_n_s)
    );

    async_sync_chain #(.W(1), .STAGES(SYNC)) u_sync_widx_valid (
        .i_clock (clock),
        .i_reset (w_rst),
        .i_d     (io_async_safe_widx_valid),
        .o_q     (w_widx_valid_s)
    );

    assign w_rst  = reset | ~w_src_rst_n_s;
    assign w_gate = w_widx_valid_s;

    always_ff @(posedge clock) begin
        if (w_rst) begin
            r_ridx_valid <= 1'b0;
        end else begin
            r_ridx_valid <= 1'b1;
        end
        r_sink_rst_n <= ~reset;
    end

    assign io_async_safe_ridx_valid   = r_ridx_valid;
    assign io_async_safe_sink_reset_n = r_sink_rst_n;
`else
    assign w_rst  = reset;
    assign w_gate = 1'b1;
`endif

    async_sync_chain #(.W(PW), .STAGES(SYNC)) u_sync_widx (
        .i_clock (clock),
        .i_reset (w_rst),
        .i_d     (io_async_widx),
        .o_q     (w_widx_s)
    );

    // Compare in the package's wide Gray space; upper bits are zero on both sides.
    assign w_rd_gray  = bin2gray(GRAY_W'(r_rd));
    assign w_nonempty = w_gate && (w_rd_gray != GRAY_W'(w_widx_s));
    assign w_idx      = r_rd[LOG_DEPTH-1:0];
    assign w_entry    = io_async_mem[int'(w_idx)*WIDTH +: WIDTH];
    assign w_load     = w_nonempty && (!r_valid || io_deq_ready);

    always_ff @(posedge clock) begin
        if (w_rst) begin
            r_rd    <= '0;
            r_ridx  <= '0;
            r_valid <= 1'b0;
            r_bits  <= '0;
        end else begin
            r_ridx <= w_rd_gray[PW-1:0];
            if (w_load) begin
                r_bits  <= w_entry;
                r_valid <= 1'b1;
                r_rd    <= r_rd + 1'b1;
            end else if (r_valid && io_deq_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign io_deq_valid  = r_valid;
    assign io_deq_bits   = r_bits;
    assign io_async_ridx = r_ridx;

endmodule

// File: tb/tb_async_rx_queue.sv
// Directed + randomized bench for async_rx_queue: a default instance and a LOG_DEPTH=2 instance.
module tb_async_rx_queue;

    localparam int SYNC_A = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: defaults
    logic          a_reset = 1'b1;
    logic          a_ready = 1'b0;
    logic          a_valid;
    logic [31:0]   a_bits;
    logic [255:0]  a_mem = '0;
    logic [3:0]    a_widx = '0;
    logic [3:0]    a_ridx;

    // Instance B: LOG_DEPTH=2, WIDTH=16, SYNC=2
    logic          b_reset = 1'b1;
    logic          b_ready = 1'b0;
    logic          b_valid;
    logic [15:0]   b_bits;
    logic [63:0]   b_mem = '0;
    logic [2:0]    b_widx = '0;
    logic [2:0]    b_ridx;

`ifdef ASYNC_RX_QUEUE_SAFE_EN
    logic a_wvalid = 1'b1;
    logic a_src_rst_n = 1'b1;
    logic a_rvalid;
    logic a_sink_rst_n;
    logic b_rvalid;
    logic b_sink_rst_n;
`endif

    async_rx_queue #(.WIDTH(32), .LOG_DEPTH(3), .SYNC(SYNC_A)) dut_a (
        .clock         (clock),
        .reset         (a_reset),
        .io_deq_ready  (a_ready),
        .io_deq_valid  (a_valid),
        .io_deq_bits   (a_bits),
        .io_async_mem  (a_mem),
        .io_async_widx (a_widx),
        .io_async_ridx (a_ridx)
`ifdef ASYNC_RX_QUEUE_SAFE_EN
        ,
        .io_async_safe_widx_valid     (a_wvalid),
        .io_async_safe_source_reset_n (a_src_rst_n),
        .io_async_safe_ridx_valid     (a_rvalid),
        .io_async_safe_sink_reset_n   (a_sink_rst_n)
`endif
    );

    async_rx_queue #(.WIDTH(16), .LOG_DEPTH(2), .SYNC(2)) dut_b (
        .clock         (clock),
        .reset         (b_reset),
        .io_deq_ready  (b_ready),
        .io_deq_valid  (b_valid),
        .io_deq_bits   (b_bits),
        .io_async_mem  (b_mem),
        .io_async_widx (b_widx),
        .io_async_ridx (b_ridx)
`ifdef ASYNC_RX_QUEUE_SAFE_EN
        ,
        .io_async_safe_widx_valid     (1'b1),
        .io_async_safe_source_reset_n (1'b1),
        .io_async_safe_ridx_valid     (b_rvalid),
        .io_async_safe_sink_reset_n   (b_sink_rst_n)
`endif
    );

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int ungray(input int g);
        int b = 0;
        for (int x = g; x != 0; x = x >> 1) b = b ^ x;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_a();
        a_reset = 1'b1;
        tick();
        tick();
        a_reset = 1'b0;
    endtask

    task automatic wait_a_valid(input string tag);
        for (int i = 0; i < 50 && !a_valid; i++) tick();
        check(tag, a_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v [3];
        logic [15:0] exp_q [$];
        logic [15:0] val;
        logic [2:0]  prev_ridx;
        int sent, got, wraps, bwr, occ, cnt;

        // Reset state
        tick();
        tick();
        check("rst_valid", a_valid, 1'b0);
        check("rst_ridx", a_ridx, 4'h0);
        check("rst_bits", a_bits, 32'h0);
        a_reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // First-entry latency from empty
        a_mem[31:0] = 32'hDEADBEEF;
        a_ready = 1'b1;
        a_widx = 4'(gray(1));
        for (int i = 1; i <= SYNC_A; i++) begin
            tick();
            check($sformatf("lat_quiet%0d", i), a_valid, 1'b0);
        end
        tick();
        check("lat_valid", a_valid, 1'b1);
        check("lat_bits", a_bits, 32'hDEADBEEF);
        tick();
        check("lat_ridx", a_ridx, 4'h1);
        check("lat_drained", a_valid, 1'b0);

        // Full ring drained back to back
        for (int i = 0; i < 8; i++) a_mem[i*32 +: 32] = 32'(i);
        a_widx = 4'(gray(8));
        reset_a();
        wait_a_valid("full_first");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("full_beat%0d_valid", k), a_valid, 1'b1);
            check($sformatf("full_beat%0d_bits", k), a_bits, 64'(k));
            tick();
        end
        check("full_end_valid", a_valid, 1'b0);
        check("full_ridx", a_ridx, 4'hC);

        // Backpressure holds output and read pointer
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v[i] = $urandom;
            a_mem[i*32 +: 32] = v[i];
        end
        a_widx = 4'(gray(3));
        reset_a();
        wait_a_valid("bp_first");
        for (int i = 0; i < 6; i++) tick();
        check("bp_valid", a_valid, 1'b1);
        check("bp_bits", a_bits, 64'(v[0]));
        check("bp_ridx", a_ridx, 64'(gray(1)));
        a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_rel%0d", i), a_bits, 64'(v[i]));
            tick();
        end
        check("bp_end_valid", a_valid, 1'b0);

        // Reset while holding a valid entry
        a_ready = 1'b0;
        a_mem[31:0] = $urandom;
        a_widx = 4'(gray(1));
        reset_a();
        wait_a_valid("rv_first");
        a_reset = 1'b1;
        tick();
        check("rv_valid", a_valid, 1'b0);
        check("rv_ridx", a_ridx, 4'h0);
        a_reset = 1'b0;

`ifdef ASYNC_RX_QUEUE_SAFE_EN
        // Source reset mid-stream
        for (int i = 0; i < 8; i++) a_mem[i*32 +: 32] = 32'(i + 100);
        a_widx = 4'(gray(8));
        reset_a();
        wait_a_valid("sr_first");
        a_ready = 1'b1;
        tick();
        a_src_rst_n = 1'b0;
        for (int i = 0; i < SYNC_A + 1; i++) tick();
        check("sr_valid", a_valid, 1'b0);
        check("sr_ridx", a_ridx, 4'h0);
        check("sr_ridx_valid", a_rvalid, 1'b0);
        a_widx = 4'h0;
        a_src_rst_n = 1'b1;
        cnt = 0;
        while (!a_rvalid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("sr_release_cycles", 64'(cnt), 64'(SYNC_A + 1));
`endif

        // Randomized stream through the 4-entry ring
        b_reset = 1'b1;
        tick();
        tick();
        b_reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        sent = 0;
        got = 0;
        wraps = 0;
        bwr = 0;
        prev_ridx = '0;
        for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
            if (b_ridx == 3'd0 && prev_ridx != 3'd0) wraps++;
            prev_ridx = b_ridx;
            b_ready = 1'($urandom_range(0, 1));
            if (b_valid && b_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", b_bits, 16'hXXXX);
                end else begin
                    check($sformatf("stream%0d", got), b_bits, exp_q.pop_front());
                end
                got++;
            end
            occ = (bwr - ungray(int'(b_ridx))) & 7;
            if (sent < 40 && occ < 4 && $urandom_range(0, 3) != 0) begin
                val = 16'($urandom);
                b_mem[(bwr % 4)*16 +: 16] = val;
                exp_q.push_back(val);
                bwr = (bwr + 1) % 8;
                b_widx = 3'(gray(bwr));
                sent++;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (b_ridx == 3'd0 && prev_ridx != 3'd0) wraps++;
            prev_ridx = b_ridx;
            tick();
        end
        check("stream_count", 64'(got), 64'd40);
        check("stream_wraps", 64'(wraps >= 2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
